// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave front end: FSM states, command codes, word width.
package spi_pkg;

    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned WORD_W     = DATA_W_DEF + 2;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    typedef enum logic [2:0] {
        StIdle,
        StChkCmd,
        StWrite,
        StReadAdd,
        StReadData
    } spi_state_e;

endpackage

// File: rtl/spi_piso.sv
// Parallel-in serial-out shifter for RAM read data; drives MISO MSB first, idles at 0.
module spi_piso #(
    parameter int unsigned Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             load_i,
    input  logic [Width-1:0] data_i,
    input  logic             shift_en_i,
    output logic             miso_o,
    output logic             done_o
);

    localparam int unsigned CntW = $clog2(Width + 1);

    logic [Width-1:0] sh_q, sh_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             miso_q, miso_d;

    always_comb begin
        sh_d   = sh_q;
        cnt_d  = cnt_q;
        miso_d = 1'b0;
        done_o = 1'b0;
        if (clear_i) begin
            sh_d  = '0;
            cnt_d = '0;
        end else if (load_i) begin
            sh_d  = data_i;
            cnt_d = CntW'(Width);
        end else if (shift_en_i && (cnt_q != '0)) begin
            miso_d = sh_q[Width-1];
            sh_d   = {sh_q[Width-2:0], 1'b0};
            cnt_d  = cnt_q - CntW'(1);
            // Flags the edge that drives the final bit.
            done_o = (cnt_q == CntW'(1));
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sh_q   <= '0;
            cnt_q  <= '0;
            miso_q <= 1'b0;
        end else begin
            sh_q   <= sh_d;
            cnt_q  <= cnt_d;
            miso_q <= miso_d;
        end
    end

    assign miso_o = miso_q;

endmodule

// File: rtl/spi_slave_if.sv
// SPI slave front end: deserializes MOSI into command words for the RAM and serializes
// read data back on MISO.
module spi_slave_if
    import spi_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                SS_n,
    input  logic                MOSI,
    output logic                MISO,
    output logic [DATA_W+1:0]   rx_data,
    output logic                rx_valid,
    input  logic [DATA_W-1:0]   tx_data,
    input  logic                tx_valid
);

    localparam int unsigned WordW  = DATA_W + 2;
    localparam logic [3:0]  LastBit = 4'(WordW - 1);
    localparam logic [3:0]  FullCnt = 4'(WordW);

    spi_state_e         state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [WordW-2:0]   shreg_q, shreg_d;
    logic [WordW-1:0]   rx_data_q, rx_data_d;
    logic               rx_valid_q, rx_valid_d;
    logic               rd_addr_flag_q, rd_addr_flag_d;
    logic               rd_wait_q, rd_wait_d;

    logic               piso_clear, piso_load, piso_shift, piso_done, piso_miso;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        shreg_d        = shreg_q;
        rx_data_d      = rx_data_q;
        rx_valid_d     = 1'b0;
        rd_addr_flag_d = rd_addr_flag_q;
        rd_wait_d      = rd_wait_q;
        piso_load      = 1'b0;
        piso_shift     = 1'b0;

        if ((state_q != StIdle) && SS_n) begin
            // Deselect drops any partial word without issuing it.
            state_d   = StIdle;
            cnt_d     = '0;
            rd_wait_d = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (!SS_n) begin
                        state_d = StChkCmd;
                        cnt_d   = '0;
                    end
                end
                StChkCmd: begin
                    shreg_d = {shreg_q[WordW-3:0], MOSI};
                    cnt_d   = 4'd1;
                    if (!MOSI)                state_d = StWrite;
                    else if (!rd_addr_flag_q) state_d = StReadAdd;
                    else                      state_d = StReadData;
                end
                StWrite, StReadAdd, StReadData: begin
                    if (cnt_q < FullCnt) begin
                        shreg_d = {shreg_q[WordW-3:0], MOSI};
                        cnt_d   = cnt_q + 4'd1;
                        if (cnt_q == LastBit) begin
                            rx_data_d  = {shreg_q, MOSI};
                            rx_valid_d = 1'b1;
                            if (state_q == StReadAdd)  rd_addr_flag_d = 1'b1;
                            if (state_q == StReadData) rd_wait_d      = 1'b1;
                        end
                    end
                    if (state_q == StReadData) begin
                        piso_shift = 1'b1;
                        if (rd_wait_q && tx_valid) begin
                            piso_load = 1'b1;
                            rd_wait_d = 1'b0;
                        end
                        if (piso_done) rd_addr_flag_d = 1'b0;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    assign piso_clear = (state_q != StReadData) || SS_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            cnt_q          <= '0;
            shreg_q        <= '0;
            rx_data_q      <= '0;
            rx_valid_q     <= 1'b0;
            rd_addr_flag_q <= 1'b0;
            rd_wait_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            shreg_q        <= shreg_d;
            rx_data_q      <= rx_data_d;
            rx_valid_q     <= rx_valid_d;
            rd_addr_flag_q <= rd_addr_flag_d;
            rd_wait_q      <= rd_wait_d;
        end
    end

    spi_piso #(
        .Width (DATA_W)
    ) u_piso (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .clear_i    (piso_clear),
        .load_i     (piso_load),
        .data_i     (tx_data),
        .shift_en_i (piso_shift),
        .miso_o     (piso_miso),
        .done_o     (piso_done)
    );

    assign MISO     = piso_miso;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;

endmodule

// File: tb/tb_spi_slave_if.sv
// Directed and randomized bench for spi_slave_if with a behavioural RAM responder and an
// abstract command/memory reference model.
module tb_spi_slave_if;
    import spi_pkg::*;

    localparam int unsigned DW = DATA_W_DEF;

    logic          clk      = 1'b0;
    logic          rst_n    = 1'b0;
    logic          SS_n     = 1'b1;
    logic          MOSI     = 1'b0;
    logic          MISO;
    logic [WORD_W-1:0] rx_data;
    logic          rx_valid;
    logic [DW-1:0] tx_data  = '0;
    logic          tx_valid = 1'b0;

    int n_total = 0;
    int n_pass  = 0;

    // Reference model state.
    logic [7:0] ref_mem [256];
    logic [7:0] ref_wr = '0;
    logic [7:0] ref_rd = '0;

    // Behavioural RAM on the far side of the interface.
    logic [7:0] ram_mem [256];
    logic [7:0] ram_wr_addr = '0;
    logic [7:0] ram_rd_addr = '0;

    always #5 clk = ~clk;

    spi_slave_if #(
        .DATA_W (DW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .SS_n     (SS_n),
        .MOSI     (MOSI),
        .MISO     (MISO),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid)
    );

    always @(posedge clk) begin
        tx_valid <= 1'b0;
        if (rx_valid) begin
            case (rx_data[9:8])
                CMD_WR_ADDR: ram_wr_addr <= rx_data[7:0];
                CMD_WR_DATA: ram_mem[ram_wr_addr] <= rx_data[7:0];
                CMD_RD_ADDR: ram_rd_addr <= rx_data[7:0];
                default: begin
                    tx_valid <= 1'b1;
                    tx_data  <= ram_mem[ram_rd_addr];
                end
            endcase
        end
    end

    task automatic chk_b(input string tag, input logic obs, input logic exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %b expected %b", tag, obs, exp);
    endtask

    task automatic chk_w(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic ref_cmd(input logic [9:0] w);
        case (w[9:8])
            2'b00:   ref_wr = w[7:0];
            2'b01:   ref_mem[ref_wr] = w[7:0];
            2'b10:   ref_rd = w[7:0];
            default: ;
        endcase
    endtask

    // Called just after a falling edge. nbits < 10 deselects on the edge carrying bit 9-nbits.
    task automatic frame(input logic [9:0] w, input int nbits);
        SS_n = 1'b0;
        MOSI = 1'b0;
        for (int k = 9; k >= 10 - nbits; k--) begin
            @(negedge clk);
            chk_b("miso_low_in_frame", MISO, 1'b0);
            chk_b("no_early_valid", rx_valid, 1'b0);
            MOSI = w[k];
        end
        @(negedge clk);
        if (nbits == 10) begin
            chk_b("rx_valid", rx_valid, 1'b1);
            chk_w("rx_data", 32'(rx_data), 32'(w));
            ref_cmd(w);
        end else begin
            chk_b("abort_pre_valid", rx_valid, 1'b0);
            SS_n = 1'b1;
            MOSI = w[9-nbits];
            repeat (2) begin
                @(negedge clk);
                chk_b("abort_no_valid", rx_valid, 1'b0);
            end
        end
    endtask

    task automatic send(input logic [9:0] w);
        frame(w, 10);
        SS_n = 1'b1;
        @(negedge clk);
        chk_b("pulse_one_cycle", rx_valid, 1'b0);
        chk_w("rx_data_held", 32'(rx_data), 32'(w));
    endtask

    task automatic readout(input logic [7:0] exp);
        @(negedge clk);
        chk_b("ram_tx_valid", tx_valid, 1'b1);
        chk_b("miso_before_load", MISO, 1'b0);
        @(negedge clk);
        chk_b("miso_at_load", MISO, 1'b0);
        for (int i = 7; i >= 0; i--) begin
            @(negedge clk);
            chk_b("miso_bit", MISO, exp[i]);
        end
        repeat (2) begin
            @(negedge clk);
            chk_b("miso_after_read", MISO, 1'b0);
        end
    endtask

    task automatic no_readout(input int n);
        repeat (n) begin
            @(negedge clk);
            chk_b("miso_read_add", MISO, 1'b0);
        end
    endtask

    task automatic read_data(input logic [7:0] pl, input logic [7:0] exp);
        frame({2'b11, pl}, 10);
        readout(exp);
        SS_n = 1'b1;
        @(negedge clk);
        chk_b("miso_idle", MISO, 1'b0);
    endtask

    initial begin
        logic [7:0] a, d, e;
        logic [9:0] w1, w2;

        repeat (2) @(negedge clk);
        chk_b("reset_miso", MISO, 1'b0);
        chk_b("reset_rx_valid", rx_valid, 1'b0);
        chk_w("reset_rx_data", 32'(rx_data), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Write address / write data.
        send(10'h03A);
        send(10'h1A5);
        chk_w("ram_3a", 32'(ram_mem[8'h3A]), 32'h0A5);

        // Read: address frame then data frame.
        send(10'h23A);
        no_readout(4);
        read_data(8'($urandom), 8'hA5);

        // Flag must be clear: a bit9=1 frame now takes READ_ADD (RAM answer ignored).
        frame(10'h300, 10);
        no_readout(12);
        SS_n = 1'b1;
        @(negedge clk);

        // Flag now set: read-out started, reset asynchronously during its third bit.
        frame(10'h355, 10);
        repeat (4) @(negedge clk);
        @(negedge clk);
        chk_b("miso_bit5_before_reset", MISO, ref_mem[ref_rd][5]);
        #1;
        rst_n = 1'b0;
        SS_n  = 1'b1;
        #1;
        chk_b("rst_miso_now", MISO, 1'b0);
        chk_b("rst_rx_valid_now", rx_valid, 1'b0);
        chk_w("rst_rx_data_now", 32'(rx_data), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        frame(10'h3C3, 10);
        no_readout(12);
        SS_n = 1'b1;
        @(negedge clk);
        read_data(8'h00, ref_mem[ref_rd]);

        // Aborts: after 6 bits, and on the bit-0 edge; the next frame still decodes.
        frame(10'h0F0, 6);
        send(10'h1FF);
        chk_w("ram_after_abort", 32'(ram_mem[8'h3A]), 32'h0FF);
        frame(10'h011, 9);
        send(10'h012);

        // Back-to-back writes with one deselected cycle between.
        w1 = {2'b00, 8'($urandom)};
        w2 = {2'b01, 8'($urandom)};
        send(w1);
        send(w2);

        // Randomized write/read round trips.
        for (int r = 0; r < 4; r++) begin
            a = 8'($urandom);
            d = 8'($urandom);
            send({2'b00, a});
            send({2'b01, d});
            e = 8'($urandom);
            send({2'b00, e});
            send({2'b01, ~d});
            send({2'b10, a});
            read_data(8'($urandom), ref_mem[a]);
            send({2'b10, e});
            read_data(8'($urandom), ref_mem[e]);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
